// File: rtl/mem_copy_engine.sv
// mem_copy_engine: ascending word-by-word block copy master, 3 cycles/word.
// Define MEM_COPY_CHECKSUM_EN to add a running sum of copied words.
module mem_copy_engine #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_WR   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;
  logic              accept;

  assign src_nxt = src_ptr + 1'b1;
  assign dst_nxt = dst_ptr + 1'b1;
  assign accept  = (state == S_IDLE) && start;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (length != '0) begin
              src_ptr   <= src_addr;
              dst_ptr   <= dst_addr;
              remaining <= length;
              mem_addr  <= src_addr;
              mem_write <= 1'b0;
              busy      <= 1'b1;
              state     <= S_RD;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RD: begin
          state <= S_CAP;
        end
        S_CAP: begin
          mem_wdata <= mem_rdata;
          mem_addr  <= dst_ptr;
          mem_write <= 1'b1;
          state     <= S_WR;
        end
        S_WR: begin
          mem_write <= 1'b0;
          src_ptr   <= src_nxt;
          dst_ptr   <= dst_nxt;
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            mem_addr <= src_nxt;
            state    <= S_RD;
          end
        end
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  // Zero-length starts also clear the sum, so they report 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (state == S_CAP) begin
      checksum <= checksum + mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: random and directed copies checked every cycle
// against a timing/memory reference model.
module tb_mem_copy_engine;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic [15:0] mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  mem_copy_engine dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] a16(input logic [15:0] b,
                                      input int unsigned k);
    return 16'(b + k);
  endfunction

  // Backdoor preload port, applied to both memories on a clock edge
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  // Registered-read memory seen by the DUT
  logic [15:0] mem [0:65535];
  int unsigned wr_cnt = 0;
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (reset) mem_rdata <= '0;
    else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end else mem_rdata <= mem[mem_addr];
  end

  // Reference model: the k-th word (k from 1) of a copy accepted at edge e0
  // commits at edge e0+3k as ref[dst+k-1] = ref[src+k-1].
  logic [15:0] ref_mem [0:65535];
  int unsigned cyc   = 0;
  logic        m_act = 1'b0;
  int unsigned m_e0  = 0;
  int unsigned m_len = 0;
  logic [15:0] m_src = '0;
  logic [15:0] m_dst = '0;
  logic [15:0] m_sum = '0;
  int unsigned mt;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (pl_en) ref_mem[pl_addr] = pl_data;
    if (reset) begin
      m_act = 1'b0;
      m_sum = '0;
    end else begin
      if (m_act) begin
        mt = cyc - m_e0;
        if (mt % 3 == 2 && mt < 3 * m_len)
          m_sum = m_sum + ref_mem[a16(m_src, mt / 3)];
        if (mt % 3 == 0 && mt > 0 && mt <= 3 * m_len)
          ref_mem[a16(m_dst, mt / 3 - 1)] = ref_mem[a16(m_src, mt / 3 - 1)];
      end
      if (start && (!m_act || cyc - m_e0 > 3 * m_len)) begin
        m_act = 1'b1;
        m_e0  = cyc;
        m_len = length;
        m_src = src_addr;
        m_dst = dst_addr;
        m_sum = '0;
      end
    end
  end

  // Per-cycle compare of all outputs against the model
  int unsigned done_cnt = 0;
  int unsigned tc;
  logic eb, ed, ew, er;
  always @(negedge clock) begin
    if (cyc > 0) begin
      tc = cyc - m_e0;
      eb = m_act && m_len != 0 && tc < 3 * m_len;
      ed = m_act && tc == 3 * m_len;
      ew = eb && tc % 3 == 2;
      er = eb && tc % 3 == 0;
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("mem_write", mem_write, ew);
      if (er) chk("rd_addr", mem_addr, a16(m_src, tc / 3));
      if (ew) begin
        chk("wr_addr", mem_addr, a16(m_dst, tc / 3));
        chk("wr_data", mem_wdata, ref_mem[a16(m_src, tc / 3)]);
      end
`ifdef MEM_COPY_CHECKSUM_EN
      chk("checksum", checksum, m_sum);
`endif
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic pre(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic do_copy(input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] n);
    int unsigned k;
    @(negedge clock);
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    src_addr = 16'($urandom); dst_addr = 16'($urandom);
    length = 16'($urandom);
    k = 0;
    while (done !== 1'b1 && k < 3 * n + 10) begin
      @(negedge clock);
      k++;
    end
    chk("done_seen", done, 1'b1);
    @(negedge clock);
  endtask

  task automatic cmp_region(input logic [15:0] b, input int unsigned n);
    for (int i = 0; i < n; i++)
      chk("region", mem[a16(b, i)], ref_mem[a16(b, i)]);
  endtask

  int unsigned w0, d0;
  logic [15:0] rs, rd, rn;

  initial begin
    reset = 1'b1; start = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wr", mem_write, 1'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_wdata", mem_wdata, 16'h0);
    reset = 1'b0;

    pre(16'd35, 16'h7C00); pre(16'd36, 16'h1400); pre(16'd37, 16'h3004);
    for (int i = 0; i < 3; i++) pre(16'(100 + i), 16'h0);
    do_copy(16'd35, 16'd100, 16'd3);
    chk("t1_100", mem[100], 16'h7C00);
    chk("t1_101", mem[101], 16'h1400);
    chk("t1_102", mem[102], 16'h3004);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("t1_sum", checksum, 16'hC004);
`endif

    w0 = wr_cnt; d0 = done_cnt;
    do_copy(16'h0500, 16'h0600, 16'd0);
    chk("len0_writes", wr_cnt - w0, 0);
    chk("len0_dones", done_cnt - d0, 1);
`ifdef MEM_COPY_CHECKSUM_EN
    chk("len0_sum", checksum, 16'h0);
`endif

    pre(16'hFFFF, 16'hAAAA); pre(16'h0000, 16'h5555);
    pre(16'h0010, 16'h0); pre(16'h0011, 16'h0);
    do_copy(16'hFFFF, 16'h0010, 16'd2);
    chk("wrap_10", mem[16'h0010], 16'hAAAA);
    chk("wrap_11", mem[16'h0011], 16'h5555);

    for (int i = 0; i < 4; i++) pre(16'(200 + i), 16'(i + 1));
    do_copy(16'd200, 16'd201, 16'd3);
    for (int i = 0; i < 4; i++) chk("overlap", mem[200 + i], 16'h1);

    for (int i = 0; i < 4; i++) begin
      pre(16'(16'h0300 + i), 16'(16'h0011 * (i + 1)));
      pre(16'(16'h0400 + i), 16'hEEEE);
    end
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge clock);
    src_addr = 16'h0300; dst_addr = 16'h0400; length = 16'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_wr", mem_write, 1'b0);
    repeat (8) @(negedge clock);
    chk("mid_rst_writes", wr_cnt - w0, 1);
    chk("mid_rst_dones", done_cnt - d0, 0);
    chk("mid_rst_400", mem[16'h0400], 16'h0011);
    chk("mid_rst_401", mem[16'h0401], 16'hEEEE);
    do_copy(16'h0300, 16'h0400, 16'd4);
    chk("after_rst_403", mem[16'h0403], 16'h0044);
    cmp_region(16'h0400, 4);

    for (int i = 0; i < 3; i++) begin
      pre(16'(16'h0700 + i), 16'(16'hBEE0 + i));
      pre(16'(16'h0800 + i), 16'h0);
    end
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge clock);
    src_addr = 16'h0700; dst_addr = 16'h0800; length = 16'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    src_addr = 16'h0900; dst_addr = 16'h0A00; length = 16'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (12) @(negedge clock);
    chk("repulse_writes", wr_cnt - w0, 3);
    chk("repulse_dones", done_cnt - d0, 1);
    chk("repulse_802", mem[16'h0802], 16'hBEE2);

    for (int it = 0; it < 20; it++) begin
      rs = 16'($urandom); rd = 16'($urandom);
      rn = 16'($urandom_range(1, 8));
      for (int i = 0; i < rn; i++) begin
        pre(a16(rs, i), 16'($urandom));
        pre(a16(rd, i), 16'($urandom));
      end
      do_copy(rs, rd, rn);
      cmp_region(rd, rn);
    end

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
